// File: rtl/mult_error_monitor.sv
// mult_error_monitor
// Scoring stage for a candidate multiplier. Operand pairs are accepted on a
// valid/ready handshake, the exact product is computed here and carried through
// a delay line matching the candidate's latency, and the candidate's output is
// scored against it. The run statistics (samples, errors, max and summed
// absolute error) form the reward read by the exploration agent.

module mult_error_monitor #(
  parameter int WIDTH       = 8,
  parameter int LAT         = 0,
  parameter int NUM_SAMPLES = 20,
  parameter int CNT_W       = 16,
  parameter int SUM_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   p_dut,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [2*WIDTH-1:0]   max_err,
  output logic [SUM_W-1:0]     sum_abs_err
);

  localparam int PW    = 2 * WIDTH;
  localparam int ACC_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam logic [ACC_W-1:0] LAST_ACC = ACC_W'(NUM_SAMPLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             clear_stats;

  logic             accept;
  logic [PW-1:0]    exp_prod;

  logic             cmp_valid;
  logic [PW-1:0]    cmp_exp;
  logic             pending;

  logic [CNT_W-1:0] sample_count_q, sample_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [PW-1:0]    max_err_q, max_err_d;
  logic [SUM_W-1:0] sum_abs_err_q, sum_abs_err_d;

  logic [PW-1:0]    diff;
  logic [SUM_W:0]   sum_ext;

  assign accept   = in_valid & (state_q == S_RUN);
  assign exp_prod = PW'(a) * PW'(b);

  // Delay line carrying {valid, exact product} so the reference lines up
  // with the candidate's output. pending is true while entries other than the
  // one being scored this cycle are still in flight.
  generate
    if (LAT == 0) begin : g_comb
      assign cmp_valid = accept;
      assign cmp_exp   = exp_prod;
      assign pending   = 1'b0;
    end else begin : g_pipe
      logic [LAT-1:0] pipe_valid_q, pipe_valid_d;
      logic [PW-1:0]  pipe_prod_q [LAT];
      logic [PW-1:0]  pipe_prod_d [LAT];

      // Shift every cycle; a bubble enters stage 0 when nothing is accepted.
      always_comb begin
        pipe_valid_d[0] = accept;
        pipe_prod_d[0]  = exp_prod;
        for (int i = 1; i < LAT; i++) begin
          pipe_valid_d[i] = pipe_valid_q[i-1];
          pipe_prod_d[i]  = pipe_prod_q[i-1];
        end
      end

      // Delay line registers; reset empties the line.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe_valid_q <= '0;
          for (int i = 0; i < LAT; i++) begin
            pipe_prod_q[i] <= '0;
          end
        end else begin
          pipe_valid_q <= pipe_valid_d;
          for (int i = 0; i < LAT; i++) begin
            pipe_prod_q[i] <= pipe_prod_d[i];
          end
        end
      end

      assign cmp_valid = pipe_valid_q[LAT-1];
      assign cmp_exp   = pipe_prod_q[LAT-1];

      if (LAT > 1) begin : g_pend
        assign pending = |pipe_valid_q[LAT-2:0];
      end else begin : g_nopend
        assign pending = 1'b0;
      end
    end
  endgenerate

  // Run control: counts accepts in RUN, waits in DRAIN until the final entry
  // is being scored, and holds results in DONE until the next start.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    clear_stats = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          acc_d       = '0;
          clear_stats = 1'b1;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (acc_q == LAST_ACC) begin
            state_d = S_DRAIN;
            acc_d   = '0;
          end else begin
            acc_d = acc_q + ACC_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!pending) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          acc_d       = '0;
          clear_stats = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        acc_d   = '0;
      end
    endcase
  end

  // FSM and accept counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  // Absolute error as larger minus smaller, and a one-bit-wider sum so the
  // carry out signals saturation.
  always_comb begin
    diff    = (p_dut >= cmp_exp) ? (p_dut - cmp_exp) : (cmp_exp - p_dut);
    sum_ext = {1'b0, sum_abs_err_q} + (SUM_W+1)'(diff);
  end

  // Statistics update: cleared on a run start, updated once per scored
  // sample, every counter saturating at all-ones.
  always_comb begin
    sample_count_d = sample_count_q;
    err_count_d    = err_count_q;
    max_err_d      = max_err_q;
    sum_abs_err_d  = sum_abs_err_q;
    if (clear_stats) begin
      sample_count_d = '0;
      err_count_d    = '0;
      max_err_d      = '0;
      sum_abs_err_d  = '0;
    end else if (cmp_valid) begin
      if (!(&sample_count_q)) begin
        sample_count_d = sample_count_q + CNT_W'(1);
      end
      if ((diff != '0) && !(&err_count_q)) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
      if (diff > max_err_q) begin
        max_err_d = diff;
      end
      if (sum_ext[SUM_W]) begin
        sum_abs_err_d = '1;
      end else begin
        sum_abs_err_d = sum_ext[SUM_W-1:0];
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_count_q <= '0;
      err_count_q    <= '0;
      max_err_q      <= '0;
      sum_abs_err_q  <= '0;
    end else begin
      sample_count_q <= sample_count_d;
      err_count_q    <= err_count_d;
      max_err_q      <= max_err_d;
      sum_abs_err_q  <= sum_abs_err_d;
    end
  end

  assign in_ready     = (state_q == S_RUN);
  assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign sample_count = sample_count_q;
  assign err_count    = err_count_q;
  assign max_err      = max_err_q;
  assign sum_abs_err  = sum_abs_err_q;

endmodule
